wb_select_stage: RTL and testbench

Parametrised register-file writeback stage for the MIPS CPU. Selects one of `NSRC` result sources (ALU, data memory, jal link PC, slt result, and future multi-cycle units) and registers the chosen value. Waits for sources that are not yet valid, with a bounded timeout. Suppresses writes to `$0`. Sits between the execute/memory results and the register-file write port; presents exactly one single-cycle write per accepted instruction.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_src_mux.sv | 39 +++
 rtl/wb_select_stage.sv | 139 +++++++++++++
 tb/tb_wb_select_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : shared state type and source-select constants for the writeback
//          select stage.                               Rev 1.0
// ============================================================================
package wb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } wb_state_e;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_DM  = 1;
  localparam int WB_SRC_JAL = 2;
  localparam int WB_SRC_SLT = 3;

  localparam int WB_DEF_WIDTH = 32;
  localparam int WB_DEF_REGW  = 5;

endpackage
`default_nettype wire

// File: rtl/wb_src_mux.sv
`default_nettype none
// ============================================================================
// wb_src_mux : NSRC-way result selector; out-of-range selects read as a
//              valid zero.                             Rev 1.0
// ============================================================================
module wb_src_mux
  import wb_pkg::*;
#(
  parameter int WIDTH = WB_DEF_WIDTH,
  parameter int NSRC  = 4,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic [SELW-1:0]       sel_i,
  input  logic [NSRC*WIDTH-1:0] src_data_i,
  input  logic [NSRC-1:0]       src_valid_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  valid_o
);

  logic [WIDTH-1:0] w_src [NSRC];

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_unpack
    assign w_src[gi] = src_data_i[gi*WIDTH +: WIDTH];
  end

  // Defaults double as the legacy out-of-range arm: data 0, always valid.
  always_comb begin
    data_o  = '0;
    valid_o = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (sel_i == SELW'(i)) begin
        data_o  = w_src[i];
        valid_o = src_valid_i[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
// wb_select_stage : register-file writeback stage; selects a result source,
//                   waits (bounded) for it, and emits one write strobe.  Rev 1.0
// ============================================================================
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int WIDTH   = WB_DEF_WIDTH,
  parameter int NSRC    = 4,
  parameter int SELW    = $clog2(NSRC),
  parameter int REGW    = WB_DEF_REGW,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SELW-1:0]       in_sel,
  input  logic [REGW-1:0]       in_rd,
  input  logic                  in_we,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_valid,
  output logic                  out_valid,
  output logic                  out_we,
  output logic [REGW-1:0]       out_rd,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err
);

  localparam int              CNTW     = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  wb_state_e        state_q, state_d;
  logic [SELW-1:0]  sel_q,   sel_d;
  logic [REGW-1:0]  rd_q,    rd_d;
  logic             we_q,    we_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             err_q,   err_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;

  logic             w_accept;
  logic             w_full;
  logic [SELW-1:0]  w_mux_sel;
  logic [WIDTH-1:0] w_mux_data;
  logic             w_mux_valid;

  assign in_ready = (state_q != WAIT);
  assign w_accept = in_valid & in_ready;
  assign w_full   = (state_q == FULL);

  // One mux serves both the accept path and the WAIT re-poll; they never overlap.
  assign w_mux_sel = (state_q == WAIT) ? sel_q : in_sel;

  wb_src_mux #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SELW  (SELW)
  ) u_src_mux (
    .sel_i       (w_mux_sel),
    .src_data_i  (src_data),
    .src_valid_i (src_valid),
    .data_o      (w_mux_data),
    .valid_o     (w_mux_valid)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    we_d    = we_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      EMPTY: ;
      WAIT: begin
        if (w_mux_valid) begin
          data_d  = w_mux_data;
          state_d = FULL;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = FULL;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      FULL:    state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    // Accept only happens in EMPTY/FULL, so it cleanly overrides the retire.
    if (w_accept) begin
      sel_d = in_sel;
      rd_d  = in_rd;
      we_d  = in_we;
      err_d = 1'b0;
      if (w_mux_valid) begin
        data_d  = w_mux_data;
        state_d = FULL;
      end else begin
        data_d  = '0;
        cnt_d   = '0;
        state_d = WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      sel_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = w_full;
  assign out_we    = w_full & we_q & (rd_q != '0) & ~err_q;
  assign out_rd    = w_full ? rd_q   : '0;
  assign out_data  = w_full ? data_q : '0;
  assign out_err   = w_full & err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_select_stage.sv
`default_nettype none
// ============================================================================
// tb_wb_select_stage : directed, table-driven bench for wb_select_stage.
//                                                      Rev 1.0
// ============================================================================
module tb_wb_select_stage;

  logic         clk;
  logic         rst;

  logic         in_valid, in_ready, in_we;
  logic [1:0]   in_sel;
  logic [4:0]   in_rd;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         out_valid, out_we, out_err;
  logic [4:0]   out_rd;
  logic [31:0]  out_data;

  logic         in_valid6, in_ready6, in_we6;
  logic [2:0]   in_sel6;
  logic [4:0]   in_rd6;
  logic [191:0] src_data6;
  logic [5:0]   src_valid6;
  logic         out_valid6, out_we6, out_err6;
  logic [4:0]   out_rd6;
  logic [31:0]  out_data6;

  int tests = 0;
  int fails = 0;

  wb_select_stage #(.WIDTH(32), .NSRC(4), .REGW(5), .TIMEOUT(15)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_rd(in_rd), .in_we(in_we),
    .src_data(src_data), .src_valid(src_valid),
    .out_valid(out_valid), .out_we(out_we), .out_rd(out_rd), .out_data(out_data), .out_err(out_err)
  );

  wb_select_stage #(.WIDTH(32), .NSRC(6), .REGW(5), .TIMEOUT(15)) u_dut6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_sel(in_sel6), .in_rd(in_rd6), .in_we(in_we6),
    .src_data(src_data6), .src_valid(src_valid6),
    .out_valid(out_valid6), .out_we(out_we6), .out_rd(out_rd6), .out_data(out_data6), .out_err(out_err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  vec_t vecs[6];
  logic [31:0] exp_b2b[4];

  initial begin
    vecs[0] = '{2'd0, 5'd8,  1'b1, 32'h11, 32'h11, 1'b1};
    vecs[1] = '{2'd1, 5'd9,  1'b1, 32'h11, 32'h22, 1'b1};
    vecs[2] = '{2'd2, 5'd31, 1'b1, 32'h11, 32'h33, 1'b1};
    vecs[3] = '{2'd3, 5'd8,  1'b0, 32'h11, 32'h44, 1'b0};
    vecs[4] = '{2'd0, 5'd0,  1'b1, 32'h05, 32'h05, 1'b0};
    vecs[5] = '{2'd2, 5'd1,  1'b1, 32'h11, 32'h33, 1'b1};
    exp_b2b[0] = 32'h11; exp_b2b[1] = 32'h22; exp_b2b[2] = 32'h33; exp_b2b[3] = 32'h44;

    rst = 1'b1;
    in_valid = 1'b0; in_sel = '0; in_rd = '0; in_we = 1'b0;
    src_data = {32'h44, 32'h33, 32'h22, 32'h11};
    src_valid = 4'hF;
    in_valid6 = 1'b0; in_sel6 = '0; in_rd6 = '0; in_we6 = 1'b0;
    src_data6 = {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    src_valid6 = 6'h3F;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_we", {31'd0, out_we}, 32'd0);
    chk("reset_out_rd", {27'd0, out_rd}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_err", {31'd0, out_err}, 32'd0);

    // Single requests from the vector table.
    for (int i = 0; i < 6; i++) begin
      src_data = {32'h44, 32'h33, 32'h22, vecs[i].alu};
      in_valid = 1'b1; in_sel = vecs[i].sel; in_rd = vecs[i].rd; in_we = vecs[i].we;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_out_we", i), {31'd0, out_we}, {31'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_out_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
      chk($sformatf("vec%0d_out_err", i), {31'd0, out_err}, 32'd0);
      tick();
      chk($sformatf("vec%0d_idle_valid", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("vec%0d_idle_data", i), out_data, 32'd0);
    end
    src_data = {32'h44, 32'h33, 32'h22, 32'h11};

    // Back-to-back sel 0..3: every cycle retires one and accepts the next.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'(i); in_rd = 5'd8; in_we = 1'b1;
      tick();
      chk($sformatf("b2b%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("b2b%0d_out_data", i), out_data, exp_b2b[i]);
      chk($sformatf("b2b%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

    // DM result arrives 3 cycles after accept.
    src_valid = 4'b1101;
    src_data[63:32] = 32'hDEAD;
    in_valid = 1'b1; in_sel = 2'd1; in_rd = 5'd9; in_we = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("wait_c%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("wait_c%0d_out_valid", c), {31'd0, out_valid}, 32'd0);
      if (c == 3) src_valid = 4'hF;
      tick();
    end
    chk("wait_out_valid", {31'd0, out_valid}, 32'd1);
    chk("wait_out_data", out_data, 32'hDEAD);
    chk("wait_out_we", {31'd0, out_we}, 32'd1);
    chk("wait_out_rd", {27'd0, out_rd}, 32'd9);
    tick();

    // DM never valid: timeout strobe with error, no write.
    src_valid = 4'b1101;
    in_valid = 1'b1; in_sel = 2'd1; in_rd = 5'd10; in_we = 1'b1;
    tick();
    in_valid = 1'b0;
    begin
      int c;
      c = 1;
      while (!out_valid && c < 40) begin
        tick();
        c++;
      end
      chk("timeout_cycle", c, 32'd16);
    end
    chk("timeout_out_err", {31'd0, out_err}, 32'd1);
    chk("timeout_out_data", out_data, 32'd0);
    chk("timeout_out_we", {31'd0, out_we}, 32'd0);
    tick();
    chk("timeout_after_err", {31'd0, out_err}, 32'd0);

    // Reset while waiting drops the request.
    in_valid = 1'b1; in_sel = 2'd1; in_rd = 5'd11; in_we = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    src_valid = 4'hF;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
        if (out_valid) seen++;
        tick();
      end
      chk("rst_no_out_valid", seen, 32'd0);
    end

    // Six-source instance: out-of-range select returns 0 immediately.
    src_valid6 = 6'h00;
    in_valid6 = 1'b1; in_sel6 = 3'd7; in_rd6 = 5'd12; in_we6 = 1'b1;
    tick();
    in_valid6 = 1'b0;
    chk("oor_out_valid", {31'd0, out_valid6}, 32'd1);
    chk("oor_out_data", out_data6, 32'd0);
    chk("oor_out_we", {31'd0, out_we6}, 32'd1);
    chk("oor_out_err", {31'd0, out_err6}, 32'd0);
    tick();
    src_valid6 = 6'h20;
    in_valid6 = 1'b1; in_sel6 = 3'd5; in_rd6 = 5'd13; in_we6 = 1'b1;
    tick();
    in_valid6 = 1'b0;
    chk("sel5_out_valid", {31'd0, out_valid6}, 32'd1);
    chk("sel5_out_data", out_data6, 32'h66);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
